vga_text_fetch_arbiter: RTL and testbench
=========================================

// Module: vga_text_fetch_arbiter
// PURPOSE
//  Shares the single-port text-buffer RAM of the VGA console between display prefetch and CPU accesses.
//  Sequences one display read per 32-px character column, driven by the vga_timing_cc counters.
//  CPU reads/writes use every other cycle; the display slot always wins.
//  Outputs the character code for the column on screen to the glyph/pixel path.
// PARAMETERS
//  COLS        32  visible text columns (x_hi 0..COLS-1)
//  ROWS        16  visible text rows (y_hi 0..ROWS-1)
//  ADDR_W       9  RAM address width; COLS*ROWS <= 2**ADDR_W
//  DATA_W       8  character code width
//  FETCH_SLOT  28  x_lo cycle in which the display read is on the RAM port; legal 1..29
//  LINE_PF_HI  40  x_hi (in hblank) in which column 0 of the next line is prefetched
// PORTS
//  clk         in   1       pixel clock (64 MHz)
//  rst_n       in   1       asynchronous active-low reset
//  x_hi        in   6       timing: column index
//  x_lo        in   5       timing: pixel within column
//  y_hi        in   5       timing: text row
//  cpu_req     in   1       CPU access request; held high until cpu_ack
//  cpu_we      in   1       1 = write, 0 = read; stable while cpu_req is high
//  cpu_addr    in   ADDR_W  CPU RAM address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       one-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data, valid when cpu_ack is high for a read
//  ram_en      out  1       RAM port enable (registered)
//  ram_we      out  1       RAM write enable (registered)
//  ram_addr    out  ADDR_W  RAM address (registered)
//  ram_wdata   out  DATA_W  RAM write data (registered)
//  ram_rdata   in   DATA_W  sync RAM: data valid the cycle after address is presented
//  char_code   out  DATA_W  character for the current column
//  char_valid  out  1       char_code belongs to a visible cell
// BEHAVIOUR
//  - Reset (async): every output and register is 0; FSM goes to IDLE; an in-flight CPU access is dropped with no ack.
//  - Display slot: the RAM port carries the display read in cycle P (x_lo==FETCH_SLOT). This cycle is decided and registered at x_lo==FETCH_SLOT-1.
//  - Display target: addr = y_hi*COLS + x_hi+1 when x_hi+1 < COLS; addr = y_hi*COLS + 0 when x_hi == LINE_PF_HI.
//  - Display fetch condition: y_hi < ROWS and one of the targets above applies; otherwise no read is issued and pf_valid <= 0.
//  - Display capture: ram_rdata is captured into pf_code and pf_valid <= 1 at the end of P+1.
//  - Column transfer: at the end of every x_lo==31 cycle, char_code <= pf_code, char_valid <= pf_valid, then pf_valid <= 0.
//    The result is that column c displays the code fetched during column c-1; column 0 displays the code fetched at LINE_PF_HI.
//  - CPU FSM IDLE: take cpu_req when the current cycle is not a display-decision cycle (x_lo!=FETCH_SLOT-1 or no fetch).
//    On take, register the RAM port for presentation in cycle Q.
//    Write: go to WR_ACK. Read: go to RD_WAIT.
//  - CPU FSM WR_ACK (cycle Q): cpu_ack=1; return to IDLE.
//  - CPU FSM RD_WAIT (cycle Q+1): cpu_rdata <= ram_rdata; go to RD_ACK.
//  - CPU FSM RD_ACK (cycle Q+2): cpu_ack=1; return to IDLE.
//  - CPU issue: no new CPU access is issued while not in IDLE. A blocked request waits exactly 1 cycle (at most once per 32 cycles).
//  - Port sharing: the RAM port carries at most one access per cycle. A CPU read whose data returns in cycle P is legal.
//  - Write data: the CPU write data is presented unmodified. Addresses >= COLS*ROWS are passed through unchecked.
//  - ram_en=0 and ram_we=0 in idle cycles.
// STRUCTURE
//  - vgaconsole_pkg: CPU FSM state encoding (IDLE/WR_ACK/RD_WAIT/RD_ACK), default COLS/ROWS, H_NEXT/V_NEXT timing constants shared with vga_timing_cc.
//  - One sub-module, vga_fetch_slot_gen: decodes x_hi/x_lo/y_hi into disp_decide, disp_capture, col_transfer and the display address. The arbiter FSM and port mux stay in the top.
// TESTING
//  1. x_hi=5,y_hi=2,no CPU -> at x_lo=28: ram_en=1, ram_we=0, ram_addr=70; ram_rdata=0x41 at x_lo=29 -> char_code=0x41, char_valid=1 from x_hi=6,x_lo=0.
//  2. CPU write addr=0x10, data=0x5A, req raised at x_lo=10 -> ram_we=1 at x_lo=11, cpu_ack at x_lo=11; RAM then holds 0x5A.
//  3. CPU read req raised at x_lo=27 (decision cycle) -> display read at 28, CPU presented at 29, cpu_ack+cpu_rdata at 31.
//  4. x_hi=40 line prefetch with y_hi=3, RAM[96]=0x33 -> char_code=0x33 valid throughout x_hi=0 of the line; x_hi=31 transfer gives char_valid=0.
//  5. y_hi=16 (vblank) -> no display ram_en for a full line; a continuous CPU write stream is acked every 2 cycles with no 1-cycle stall.
//  6. rst_n low during RD_WAIT -> all outputs 0 immediately, no cpu_ack; after release, first display fetch resumes at next FETCH_SLOT.

Source files
------------

// File: rtl/vga_text_fetch_arbiter_pkg.sv
// Shared definitions for the VGA text console: CPU port FSM encoding and
// the character-grid / horizontal-vertical timing constants used with vga_timing_cc.
package vga_text_fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACK  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_ACK  = 2'd3
    } cpu_state_t;

    localparam int DEF_COLS = 32;
    localparam int DEF_ROWS = 16;
    // x_hi wraps after column LINE_PF_HI, so its prefetch lands in column 0.
    localparam int H_NEXT   = 41;
    localparam int V_NEXT   = 17;

endpackage

// File: rtl/vga_text_fetch_arbiter_if.sv
// CPU access bus into the text-buffer arbiter: request/ack handshake plus
// address, write data and read data.
interface vga_text_fetch_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vga_text_fetch_arbiter_slot_gen.sv
// Decodes the timing counters into the display fetch decision, capture and
// column-transfer strobes, and the text-buffer address of the next cell.
module vga_text_fetch_arbiter_slot_gen #(
    parameter int COLS       = 32,
    parameter int ROWS       = 16,
    parameter int ADDR_W     = 9,
    parameter int FETCH_SLOT = 28,
    parameter int LINE_PF_HI = 40
) (
    input  logic [5:0]        x_hi,
    input  logic [4:0]        x_lo,
    input  logic [4:0]        y_hi,
    output logic              disp_decide,
    output logic              disp_capture,
    output logic              col_transfer,
    output logic [ADDR_W-1:0] disp_addr
);
    logic [6:0]        x_next;
    logic              next_in_row;
    logic              line_pf;
    logic              row_vis;
    logic              fetch;
    logic [ADDR_W-1:0] row_base;

    always_comb begin
        x_next       = {1'b0, x_hi} + 7'd1;
        next_in_row  = x_next < 7'(COLS);
        line_pf      = x_hi == 6'(LINE_PF_HI);
        row_vis      = {1'b0, y_hi} < 6'(ROWS);
        fetch        = row_vis && (next_in_row || line_pf);
        row_base     = ADDR_W'(y_hi) * ADDR_W'(COLS);
        // The in-row target takes precedence; the line prefetch always reads column 0.
        disp_addr    = row_base + (next_in_row ? ADDR_W'(x_next) : '0);
        disp_decide  = fetch && (x_lo == 5'(FETCH_SLOT - 1));
        disp_capture = fetch && (x_lo == 5'(FETCH_SLOT + 1));
        col_transfer = x_lo == 5'd31;
    end
endmodule

// File: rtl/vga_text_fetch_arbiter.sv
// Shares the single-port text RAM between the per-column display prefetch
// and CPU accesses; the display slot always wins the port.
module vga_text_fetch_arbiter
    import vga_text_fetch_arbiter_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int FETCH_SLOT = 28,
    parameter int LINE_PF_HI = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               x_hi,
    input  logic [4:0]               x_lo,
    input  logic [4:0]               y_hi,
    vga_text_fetch_arbiter_if.slave  cpu,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [DATA_W-1:0]        char_code,
    output logic                     char_valid
);
    cpu_state_t        state;
    logic              rd_vld_p1;
    logic [DATA_W-1:0] pf_code;
    logic              pf_valid;
    logic              disp_decide;
    logic              disp_capture;
    logic              col_transfer;
    logic [ADDR_W-1:0] disp_addr;
    logic              cpu_take;

    vga_text_fetch_arbiter_slot_gen #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_W     (ADDR_W),
        .FETCH_SLOT (FETCH_SLOT),
        .LINE_PF_HI (LINE_PF_HI)
    ) u_slot_gen (
        .x_hi         (x_hi),
        .x_lo         (x_lo),
        .y_hi         (y_hi),
        .disp_decide  (disp_decide),
        .disp_capture (disp_capture),
        .col_transfer (col_transfer),
        .disp_addr    (disp_addr)
    );

    assign cpu_take = (state == ST_IDLE) && cpu.cpu_req && !disp_decide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rd_vld_p1     <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= '0;
        end else begin
            // Port mux: registered here, on the RAM pins next cycle.
            if (disp_decide) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= disp_addr;
            end else if (cpu_take) begin
                ram_en    <= 1'b1;
                ram_we    <= cpu.cpu_we;
                ram_addr  <= cpu.cpu_addr;
                ram_wdata <= cpu.cpu_wdata;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cpu.cpu_ack <= 1'b0;
                    if (cpu_take) begin
                        rd_vld_p1   <= 1'b0;
                        cpu.cpu_ack <= cpu.cpu_we;
                        state       <= cpu.cpu_we ? ST_WR_ACK : ST_RD_WAIT;
                    end
                end
                ST_WR_ACK: begin
                    cpu.cpu_ack <= 1'b0;
                    state       <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    // First RD_WAIT cycle has the address on the port; data returns in the second.
                    if (rd_vld_p1) begin
                        cpu.cpu_rdata <= ram_rdata;
                        cpu.cpu_ack   <= 1'b1;
                        rd_vld_p1     <= 1'b0;
                        state         <= ST_RD_ACK;
                    end else begin
                        rd_vld_p1 <= 1'b1;
                    end
                end
                ST_RD_ACK: begin
                    cpu.cpu_ack <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_code    <= '0;
            pf_valid   <= 1'b0;
            char_code  <= '0;
            char_valid <= 1'b0;
        end else begin
            // Column boundary: the prefetched cell becomes the displayed cell.
            if (col_transfer) begin
                char_code  <= pf_code;
                char_valid <= pf_valid;
                pf_valid   <= 1'b0;
            end else if (disp_capture) begin
                pf_code  <= ram_rdata;
                pf_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_text_fetch_arbiter.sv
// Bench for the text fetch arbiter: free-running timing counters, a sync RAM,
// a random CPU master and a cell-level reference model of the display path.
module tb_vga_text_fetch_arbiter;
    import vga_text_fetch_arbiter_pkg::*;

    localparam int COLS       = DEF_COLS;
    localparam int ROWS       = DEF_ROWS;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 8;
    localparam int FETCH_SLOT = 28;
    localparam int LINE_PF_HI = 40;
    localparam int MEM_N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [5:0]        x_hi;
    logic [4:0]        x_lo;
    logic [4:0]        y_hi;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] char_code;
    logic              char_valid;

    vga_text_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_text_fetch_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FETCH_SLOT(FETCH_SLOT), .LINE_PF_HI(LINE_PF_HI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_hi       (x_hi),
        .x_lo       (x_lo),
        .y_hi       (y_hi),
        .cpu        (bus.slave),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .char_code  (char_code),
        .char_valid (char_valid)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         cpu_q_cyc = -1;
    bit         load_mem = 1'b1;
    logic [7:0] ref_mem [MEM_N];
    logic [7:0] ram_mem [MEM_N];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit fetch_ok(input int xh, input int yh);
        return (yh < ROWS) && ((xh + 1 < COLS) || (xh == LINE_PF_HI));
    endfunction

    function automatic int fetch_addr(input int xh, input int yh);
        return yh * COLS + ((xh + 1 < COLS) ? xh + 1 : 0);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sync RAM; output is noise except in the cycle after a read.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_N; i++) ram_mem[i] <= ref_mem[i];
            ram_rdata <= '0;
        end else begin
            if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
            if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr];
            else ram_rdata <= 8'($urandom);
        end
    end

    initial begin
        x_lo = '0; x_hi = '0; y_hi = 5'd15;
        forever begin
            @(posedge clk); #1;
            if (x_lo == 5'd31) begin
                x_lo = '0;
                if (int'(x_hi) == H_NEXT - 1) begin
                    x_hi = '0;
                    y_hi = (int'(y_hi) == V_NEXT - 1) ? 5'd0 : y_hi + 5'd1;
                end else begin
                    x_hi = x_hi + 6'd1;
                end
            end else begin
                x_lo = x_lo + 5'd1;
            end
        end
    end

    // Cell-level display model: a cell fetched in column c shows during column c+1.
    bit         cur_v = 0, nxt_v = 0;
    logic [7:0] cur_c = '0, nxt_c = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_eq("rst_ram_en", 32'(ram_en), 0);
                chk_eq("rst_ram_we", 32'(ram_we), 0);
                chk_eq("rst_ram_addr", 32'(ram_addr), 0);
                chk_eq("rst_ram_wdata", 32'(ram_wdata), 0);
                chk_eq("rst_cpu_ack", 32'(bus.cpu_ack), 0);
                chk_eq("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
                chk_eq("rst_char_code", 32'(char_code), 0);
                chk_eq("rst_char_valid", 32'(char_valid), 0);
                cur_v = 0; nxt_v = 0; cur_c = '0; nxt_c = '0;
            end else begin
                if (x_lo == 5'd0) begin
                    cur_v = nxt_v; cur_c = nxt_c; nxt_v = 0;
                end
                chk_eq("char_valid", 32'(char_valid), 32'(cur_v));
                if (cur_v) chk_eq("char_code", 32'(char_code), 32'(cur_c));
                if (int'(x_lo) == FETCH_SLOT && fetch_ok(int'(x_hi), int'(y_hi))) begin
                    chk_eq("disp_en", 32'(ram_en), 1);
                    chk_eq("disp_we", 32'(ram_we), 0);
                    chk_eq("disp_addr", 32'(ram_addr), 32'(fetch_addr(int'(x_hi), int'(y_hi))));
                    nxt_v = 1;
                    nxt_c = ref_mem[fetch_addr(int'(x_hi), int'(y_hi))];
                end else if (cyc != cpu_q_cyc) begin
                    chk_eq("idle_en", 32'(ram_en), 0);
                    chk_eq("idle_we", 32'(ram_we), 0);
                end
                if (x_hi == 6'd5 && y_hi == 5'd2 && int'(x_lo) == FETCH_SLOT)
                    chk_eq("t1_addr", 32'(ram_addr), 70);
                if (x_hi == 6'd6 && y_hi == 5'd2 && x_lo == 5'd0) begin
                    chk_eq("t1_char", 32'(char_code), 32'h41);
                    chk_eq("t1_valid", 32'(char_valid), 1);
                end
                if (x_hi == 6'd0 && y_hi == 5'd4 && x_lo == 5'd31) begin
                    chk_eq("t4_char", 32'(char_code), 32'h33);
                    chk_eq("t4_valid", 32'(char_valid), 1);
                end
                if (x_hi == 6'd32 && y_hi < 5'(ROWS) && x_lo == 5'd1)
                    chk_eq("t4_col32_invalid", 32'(char_valid), 0);
            end
        end
    end

    // One CPU transaction; entered and left just after a rising edge.
    task automatic cpu_op(input bit we, input int a, input int d, output int lat, output int ack_c);
        int t, tk, qc, exp_ack;
        bit got;
        bus.cpu_req = 1'b1; bus.cpu_we = we;
        bus.cpu_addr = ADDR_W'(a); bus.cpu_wdata = DATA_W'(d);
        @(negedge clk);
        t  = cyc;
        tk = (int'(x_lo) == FETCH_SLOT - 1 && fetch_ok(int'(x_hi), int'(y_hi))) ? t + 1 : t;
        qc = tk + 1;
        cpu_q_cyc = qc;
        exp_ack = we ? tk + 1 : tk + 3;
        got = 0; lat = -1; ack_c = -1;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk);
            if (cyc == qc) begin
                chk_eq("cpu_en", 32'(ram_en), 1);
                chk_eq("cpu_we", 32'(ram_we), 32'(we));
                chk_eq("cpu_addr", 32'(ram_addr), 32'(a));
                if (we) chk_eq("cpu_wdata", 32'(ram_wdata), 32'(d));
            end
            if (bus.cpu_ack) begin
                got = 1; lat = cyc - t; ack_c = cyc;
                chk_eq("ack_cycle", 32'(cyc), 32'(exp_ack));
                if (!we) chk_eq("cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[a]));
                break;
            end
        end
        if (!got) chk_eq("ack_timeout", 0, 1);
        if (we) ref_mem[a] = 8'(d);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_at(input int xl, input int yh, input int xh, input int bound);
        bit ok = 0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if ((xl < 0 || int'(x_lo) == xl) && (yh < 0 || int'(y_hi) == yh) &&
                (xh < 0 || int'(x_hi) == xh)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk_eq("wait_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    function automatic int rand_addr();
        int a = int'($urandom_range(MEM_N - 1, 0));
        if (a == 70 || a == 96) a = a + 1;
        return a;
    endfunction

    task automatic rand_ops_until(input int yh, input int xh, input int bound);
        int lat, ackc, guard = 0;
        while (!(int'(y_hi) == yh && int'(x_hi) == xh)) begin
            cpu_op(bit'($urandom_range(1, 0)), rand_addr(), int'($urandom_range(255, 0)), lat, ackc);
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            guard++;
            if (guard > bound) begin
                chk_eq("rand_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ackc, prev_ack, t;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = 8'($urandom);
        ref_mem[70] = 8'h41;
        ref_mem[96] = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        load_mem = 1'b0;
        rst_n = 1'b1;

        // Write at x_lo=10, then read it back.
        wait_at(9, -1, -1, 64);
        cpu_op(1'b1, 16, 8'h5A, lat, ackc);
        chk_eq("t2_lat", 32'(lat), 1);
        cpu_op(1'b0, 16, 0, lat, ackc);
        chk_eq("t2_rd_lat", 32'(lat), 3);

        // Read raised in the display decision cycle.
        wait_at(26, 15, 10, 2000);
        cpu_op(1'b0, rand_addr(), 0, lat, ackc);
        chk_eq("t3_lat", 32'(lat), 4);

        rand_ops_until(15, 30, 2000);

        // Vblank row: back-to-back writes, never stalled.
        wait_at(0, 16, 0, 4000);
        prev_ack = -1;
        for (int i = 0; i < 60; i++) begin
            cpu_op(1'b1, rand_addr(), int'($urandom_range(255, 0)), lat, ackc);
            chk_eq("t5_lat", 32'(lat), 1);
            if (prev_ack >= 0) chk_eq("t5_gap", 32'(ackc - prev_ack), 2);
            prev_ack = ackc;
        end

        rand_ops_until(0, 2, 4000);

        // Reset asserted while a read sits in RD_WAIT.
        wait_at(20, -1, -1, 64);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ADDR_W'(rand_addr());
        @(negedge clk);
        t = cyc;
        cpu_q_cyc = t + 1;
        @(negedge clk);
        chk_eq("t6_port_before_rst", 32'(ram_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_ram_en", 32'(ram_en), 0);
        chk_eq("t6_ram_addr", 32'(ram_addr), 0);
        chk_eq("t6_cpu_ack", 32'(bus.cpu_ack), 0);
        chk_eq("t6_char_code", 32'(char_code), 0);
        chk_eq("t6_char_valid", 32'(char_valid), 0);
        repeat (3) begin
            @(negedge clk);
            chk_eq("t6_no_ack", 32'(bus.cpu_ack), 0);
        end
        wait_at(4, -1, -1, 64);
        rst_n = 1'b1;
        bus.cpu_req = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk_eq("t6_no_late_ack", 32'(bus.cpu_ack), 0);
        end
        @(posedge clk); #1;

        rand_ops_until(4, 1, 20000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
